branch_resolve_unit: RTL and testbench



---
 rtl/branch_resolve_unit_pkg.sv | 26 ++
 rtl/branch_resolve_unit_cmp.sv | 45 ++++
 rtl/branch_resolve_unit.sv | 246 ++++++++++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_resolve_unit_pkg.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit_pkg
// Shared constants for the branch resolution stage:
//   - BR_* conditional-branch func3 encodings
//   - default fall-through increment (instruction length in bytes)
//   - width of the packed branch result {taken, mispredict, illegal, next_pc}
// -----------------------------------------------------------------------------
package branch_resolve_unit_pkg;

    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

    localparam int ILEN_BYTES_DEFAULT = 4;

    // Flag bits carried next to the PC in a resolved result: taken, mispredict, illegal.
    localparam int BR_RESULT_FLAGS_W = 3;

    function automatic int br_result_width(input int xlen);
        return xlen + BR_RESULT_FLAGS_W;
    endfunction

endpackage

// File: rtl/branch_resolve_unit_cmp.sv
// -----------------------------------------------------------------------------
// branch_cmp
// Purely combinational conditional-branch evaluator.
// Ports:
//   func3_i    [2:0]       branch func3
//   rs1_i      [XLEN-1:0]  operand A
//   rs2_i      [XLEN-1:0]  operand B
//   taken_o                branch condition holds (0 for non-branch encodings)
//   illegal_o              func3 is not a conditional-branch encoding
// -----------------------------------------------------------------------------
module branch_cmp
    import branch_resolve_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      func3_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic            taken_o,
    output logic            illegal_o
);

    logic eq;
    logic lt_s;
    logic lt_u;

    assign eq   = (rs1_i == rs2_i);
    assign lt_s = ($signed(rs1_i) < $signed(rs2_i));
    assign lt_u = (rs1_i < rs2_i);

    always_comb begin
        taken_o   = 1'b0;
        illegal_o = 1'b0;
        case (func3_i)
            BR_BEQ:  taken_o = eq;
            BR_BNE:  taken_o = !eq;
            BR_BLT:  taken_o = lt_s;
            BR_BGE:  taken_o = !lt_s;
            BR_BLTU: taken_o = lt_u;
            BR_BGEU: taken_o = !lt_u;
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit
// Pipelined branch resolution stage between the ID/EX register and the
// PC-redirect logic. Evaluates func3, computes target (pc+imm) and
// fall-through (pc+ILEN_BYTES), and flags a mispredict against the fetch
// prediction. Valid/ready on both sides, flushable.
//
// Parameters:
//   XLEN        operand / PC width (32 or 64)
//   STAGES      1: compare+target in one register stage
//               2: compare registered in stage 1, target/mispredict in stage 2
//   ILEN_BYTES  fall-through increment
//
// Ports:
//   clk, rst (async, active-high), flush
//   in_valid/in_ready, in_func3, in_rs1, in_rs2, in_pc, in_imm,
//   in_pred_taken, in_pred_target                         -- request side
//   out_valid/out_ready, out_taken, out_next_pc,
//   out_mispredict, out_illegal                           -- result side
//
// Optional build macro BRANCH_STATS_EN adds stat_branches[31:0] and
// stat_mispredicts[31:0] transfer counters (cleared by rst only).
// -----------------------------------------------------------------------------
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int STAGES     = 1,
    parameter int ILEN_BYTES = ILEN_BYTES_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_func3,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_imm,
    input  logic            in_pred_taken,
    input  logic [XLEN-1:0] in_pred_target,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_taken,
    output logic [XLEN-1:0] out_next_pc,
    output logic            out_mispredict,
    output logic            out_illegal
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
`endif
);

    localparam int RES_W = br_result_width(XLEN);

    // Entry held between compare and target stages when STAGES == 2.
    typedef struct packed {
        logic            taken;
        logic            illegal;
        logic            pred_taken;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pred_target;
    } s1_t;

    // ---------------------------------------------------------------- compare
    logic cmp_taken;
    logic cmp_illegal;

    branch_cmp #(
        .XLEN (XLEN)
    ) u_cmp (
        .func3_i   (in_func3),
        .rs1_i     (in_rs1),
        .rs2_i     (in_rs2),
        .taken_o   (cmp_taken),
        .illegal_o (cmp_illegal)
    );

    // Source of the output stage: either the raw request (1 stage) or the
    // registered compare stage (2 stages).
    logic            src_valid;
    logic            src_taken;
    logic            src_illegal;
    logic            src_pred_taken;
    logic [XLEN-1:0] src_pc;
    logic [XLEN-1:0] src_imm;
    logic [XLEN-1:0] src_pred_target;

    logic            out_valid_q;
    logic            out_valid_d;
    logic [RES_W-1:0] out_res_q;
    logic [RES_W-1:0] out_res_d;
    logic            out_accept;

    // Output register can take a new entry when empty or draining this cycle.
    assign out_accept = !out_valid_q || out_ready;

    generate
        if (STAGES == 1) begin : g_one_stage
            assign src_valid       = in_valid;
            assign src_taken       = cmp_taken;
            assign src_illegal     = cmp_illegal;
            assign src_pred_taken  = in_pred_taken;
            assign src_pc          = in_pc;
            assign src_imm         = in_imm;
            assign src_pred_target = in_pred_target;
            assign in_ready        = out_accept;
        end else begin : g_two_stage
            logic s1_valid_q;
            logic s1_valid_d;
            s1_t  s1_q;
            s1_t  s1_d;
            logic s1_load;

            // Stage 1 moves whenever the output stage accepts, so in_ready
            // depends only on out_ready and register state.
            assign in_ready = !s1_valid_q || out_accept;
            assign s1_load  = in_valid && in_ready;

            always_comb begin
                s1_valid_d = s1_valid_q;
                if (flush) begin
                    s1_valid_d = 1'b0;
                end else if (in_ready) begin
                    s1_valid_d = in_valid;
                end
            end

            always_comb begin
                s1_d = s1_q;
                if (s1_load) begin
                    s1_d.taken       = cmp_taken;
                    s1_d.illegal     = cmp_illegal;
                    s1_d.pred_taken  = in_pred_taken;
                    s1_d.pc          = in_pc;
                    s1_d.imm         = in_imm;
                    s1_d.pred_target = in_pred_target;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s1_valid_q <= 1'b0;
                end else begin
                    s1_valid_q <= s1_valid_d;
                end
            end

            // Payload is qualified by s1_valid_q, so it carries no reset.
            always_ff @(posedge clk) begin
                s1_q <= s1_d;
            end

            assign src_valid       = s1_valid_q;
            assign src_taken       = s1_q.taken;
            assign src_illegal     = s1_q.illegal;
            assign src_pred_taken  = s1_q.pred_taken;
            assign src_pc          = s1_q.pc;
            assign src_imm         = s1_q.imm;
            assign src_pred_target = s1_q.pred_target;
        end
    endgenerate

    // ---------------------------------------------------------- target stage
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] fall_through;
    logic            res_mispredict;
    logic            out_load;

    assign target       = src_pc + src_imm;
    assign fall_through = src_pc + XLEN'(ILEN_BYTES);
    assign out_load     = src_valid && out_accept;

    // Illegal encodings never redirect; their taken is already forced to 0.
    assign res_mispredict = !src_illegal &&
                            ((src_taken != src_pred_taken) ||
                             (src_taken && (src_pred_target != target)));

    always_comb begin
        out_valid_d = out_valid_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (out_accept) begin
            out_valid_d = src_valid;
        end
    end

    // Result only changes on a real load, keeping outputs stable while stalled.
    always_comb begin
        out_res_d = out_res_q;
        if (out_load) begin
            out_res_d = {src_taken, res_mispredict, src_illegal,
                         (src_taken ? target : fall_through)};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_res_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_res_q   <= out_res_d;
        end
    end

    assign out_valid = out_valid_q;
    assign {out_taken, out_mispredict, out_illegal, out_next_pc} = out_res_q;

`ifdef BRANCH_STATS_EN
    // ------------------------------------------------------------ statistics
    logic [31:0] stat_br_q;
    logic [31:0] stat_br_d;
    logic [31:0] stat_mp_q;
    logic [31:0] stat_mp_d;

    always_comb begin
        stat_br_d = stat_br_q;
        stat_mp_d = stat_mp_q;
        if (out_valid_q && out_ready) begin
            stat_br_d = stat_br_q + 32'd1;
            if (out_mispredict) begin
                stat_mp_d = stat_mp_q + 32'd1;
            end
        end
    end

    // Counters deliberately ignore flush: they record delivered results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else begin
            stat_br_q <= stat_br_d;
            stat_mp_q <= stat_mp_d;
        end
    end

    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mp_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve_unit
// Two instances (STAGES=1 and STAGES=2, XLEN=32) exercised one after the other
// with directed and $urandom stimulus. Expected results come from a
// behavioural model applied to each accepted request and queued in order.
// -----------------------------------------------------------------------------
module tb_branch_resolve_unit;
    import branch_resolve_unit_pkg::*;

    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic            flush          [2];
    logic            in_valid       [2];
    logic            in_ready       [2];
    logic [2:0]      in_func3       [2];
    logic [XLEN-1:0] in_rs1         [2];
    logic [XLEN-1:0] in_rs2         [2];
    logic [XLEN-1:0] in_pc          [2];
    logic [XLEN-1:0] in_imm         [2];
    logic            in_pred_taken  [2];
    logic [XLEN-1:0] in_pred_target [2];
    logic            out_valid      [2];
    logic            out_ready      [2];
    logic            out_taken      [2];
    logic [XLEN-1:0] out_next_pc    [2];
    logic            out_mispredict [2];
    logic            out_illegal    [2];
`ifdef BRANCH_STATS_EN
    logic [31:0]     stat_branches    [2];
    logic [31:0]     stat_mispredicts [2];
`endif

    int vec_count  = 0;
    int fail_count = 0;
    int pending    [2];
    int stall_cnt  [2];
    bit rand_ready [2];
    int cyc = 0;

    always @(posedge clk) cyc = cyc + 1;

    typedef struct {
        logic            taken;
        logic            illegal;
        logic            mispredict;
        logic [XLEN-1:0] next_pc;
        int              acc;
    } exp_t;

    // Reference: what a branch must resolve to, straight from the ISA rules.
    function automatic exp_t model(input logic [2:0] f, input logic [XLEN-1:0] a,
                                   input logic [XLEN-1:0] b, input logic [XLEN-1:0] pc,
                                   input logic [XLEN-1:0] imm, input logic pt,
                                   input logic [XLEN-1:0] ptg);
        exp_t e;
        logic [XLEN-1:0] tgt;
        e.illegal = (f == 3'd2) || (f == 3'd3);
        case (f)
            3'd0:    e.taken = (a == b);
            3'd1:    e.taken = (a != b);
            3'd4:    e.taken = ($signed(a) <  $signed(b));
            3'd5:    e.taken = ($signed(a) >= $signed(b));
            3'd6:    e.taken = (a <  b);
            3'd7:    e.taken = (a >= b);
            default: e.taken = 1'b0;
        endcase
        tgt        = pc + imm;
        e.next_pc  = e.taken ? tgt : pc + 32'd4;
        e.mispredict = e.illegal ? 1'b0 : ((e.taken != pt) || (e.taken && ptg != tgt));
        e.acc      = 0;
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_count++;
        if (act !== exp) begin
            fail_count++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------- instances
    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        exp_t q[$];
        bit   front_seen = 1'b0;
        int   last_stall = -100;
`ifdef BRANCH_STATS_EN
        logic [31:0] exp_br = '0;
        logic [31:0] exp_mp = '0;
`endif

        branch_resolve_unit #(
            .XLEN       (XLEN),
            .STAGES     (gi + 1),
            .ILEN_BYTES (4)
        ) u_dut (
            .clk            (clk),
            .rst            (rst),
            .flush          (flush[gi]),
            .in_valid       (in_valid[gi]),
            .in_ready       (in_ready[gi]),
            .in_func3       (in_func3[gi]),
            .in_rs1         (in_rs1[gi]),
            .in_rs2         (in_rs2[gi]),
            .in_pc          (in_pc[gi]),
            .in_imm         (in_imm[gi]),
            .in_pred_taken  (in_pred_taken[gi]),
            .in_pred_target (in_pred_target[gi]),
            .out_valid      (out_valid[gi]),
            .out_ready      (out_ready[gi]),
            .out_taken      (out_taken[gi]),
            .out_next_pc    (out_next_pc[gi]),
            .out_mispredict (out_mispredict[gi]),
            .out_illegal    (out_illegal[gi])
`ifdef BRANCH_STATS_EN
            ,
            .stat_branches    (stat_branches[gi]),
            .stat_mispredicts (stat_mispredicts[gi])
`endif
        );

        // Compare process: inputs and outputs are stable at the falling edge.
        always @(negedge clk) begin
            exp_t e;
            if (rst) begin
                q.delete();
                front_seen = 1'b0;
`ifdef BRANCH_STATS_EN
                exp_br = '0;
                exp_mp = '0;
`endif
            end else begin
`ifdef BRANCH_STATS_EN
                check($sformatf("s%0d_stat_branches", gi + 1), stat_branches[gi], exp_br);
                check($sformatf("s%0d_stat_mispredicts", gi + 1), stat_mispredicts[gi], exp_mp);
`endif
                if (out_valid[gi]) begin
                    check($sformatf("s%0d_out_has_request", gi + 1), q.size() != 0, 1);
                    if (q.size() != 0) begin
                        e = q[0];
                        if (!front_seen) begin
                            if (last_stall < e.acc)
                                check($sformatf("s%0d_latency", gi + 1), cyc - e.acc, gi + 1);
                            else
                                check($sformatf("s%0d_latency_min", gi + 1), (cyc - e.acc) >= gi + 1, 1);
                        end
                        front_seen = 1'b1;
                        check($sformatf("s%0d_taken", gi + 1), out_taken[gi], e.taken);
                        check($sformatf("s%0d_illegal", gi + 1), out_illegal[gi], e.illegal);
                        check($sformatf("s%0d_mispredict", gi + 1), out_mispredict[gi], e.mispredict);
                        check($sformatf("s%0d_next_pc", gi + 1), out_next_pc[gi], e.next_pc);
                        if (out_ready[gi]) begin
                            void'(q.pop_front());
                            front_seen = 1'b0;
`ifdef BRANCH_STATS_EN
                            exp_br = exp_br + 32'd1;
                            if (e.mispredict) exp_mp = exp_mp + 32'd1;
`endif
                        end
                    end
                    if (!out_ready[gi]) last_stall = cyc;
                end
                if (flush[gi]) begin
                    q.delete();
                    front_seen = 1'b0;
                end else if (in_valid[gi] && in_ready[gi]) begin
                    e = model(in_func3[gi], in_rs1[gi], in_rs2[gi], in_pc[gi], in_imm[gi],
                              in_pred_taken[gi], in_pred_target[gi]);
                    e.acc = cyc;
                    q.push_back(e);
                end
            end
            pending[gi] = q.size();
        end
    end

    // -------------------------------------------------------- consumer ready
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (stall_cnt[i] > 0) begin
                    out_ready[i] = 1'b0;
                    stall_cnt[i]--;
                end else begin
                    out_ready[i] = rand_ready[i] ? ($urandom_range(0, 3) != 0) : 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------- stimulus
    task automatic send(input int idx, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] pc, input logic [31:0] imm,
                        input logic pt, input logic [31:0] ptg);
        bit done;
        done = 1'b0;
        in_valid[idx]       = 1'b1;
        in_func3[idx]       = f;
        in_rs1[idx]         = a;
        in_rs2[idx]         = b;
        in_pc[idx]          = pc;
        in_imm[idx]         = imm;
        in_pred_taken[idx]  = pt;
        in_pred_target[idx] = ptg;
        for (int g = 0; g < 200 && !done; g++) begin
            @(negedge clk);
            done = in_ready[idx] && !flush[idx];
            @(posedge clk);
            #1;
        end
        if (!done) begin
            vec_count++;
            fail_count++;
            $display("FAIL s%0d_accept_timeout: in_ready never seen within 200 cycles", idx + 1);
        end
    endtask

    task automatic rnd_send(input int idx);
        logic [31:0] a, b, pc, imm, ptg;
        logic pt;
        a   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
        b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
        pc  = $urandom & 32'hFFFF_FFFC;
        imm = $urandom & 32'hFFFF_FFFE;
        pt  = 1'($urandom_range(0, 1));
        ptg = ($urandom_range(0, 1) == 1) ? pc + imm : $urandom;
        send(idx, 3'($urandom_range(0, 7)), a, b, pc, imm, pt, ptg);
    endtask

    task automatic idle(input int idx, input int n);
        in_valid[idx] = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_zero_outputs(input string tag, input int idx);
        check($sformatf("%s_s%0d_out_valid", tag, idx + 1), out_valid[idx], 0);
        check($sformatf("%s_s%0d_out_taken", tag, idx + 1), out_taken[idx], 0);
        check($sformatf("%s_s%0d_out_mispredict", tag, idx + 1), out_mispredict[idx], 0);
        check($sformatf("%s_s%0d_out_illegal", tag, idx + 1), out_illegal[idx], 0);
        check($sformatf("%s_s%0d_out_next_pc", tag, idx + 1), out_next_pc[idx], 0);
    endtask

    task automatic drain(input int idx);
        in_valid[idx]   = 1'b0;
        rand_ready[idx] = 1'b0;
        stall_cnt[idx]  = 0;
        for (int g = 0; g < 300; g++) begin
            @(negedge clk);
            #1;
            if (pending[idx] == 0 && !out_valid[idx]) break;
        end
        check($sformatf("s%0d_drain_pending", idx + 1), pending[idx], 0);
    endtask

    task automatic run_suite(input int idx);
        logic [2:0]  f6 [6];
        logic [31:0] snap_br, snap_mp;
        f6 = '{BR_BEQ, BR_BNE, BR_BLT, BR_BGE, BR_BLTU, BR_BGEU};
        rand_ready[idx] = 1'b0;
        stall_cnt[idx]  = 0;
        idle(idx, 2);

        // Directed compare vectors, back to back.
        for (int k = 0; k < 6; k++) send(idx, f6[k], 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h40, 1'b0, 32'h0);
        for (int k = 0; k < 6; k++) send(idx, f6[k], 32'h5, 32'h5, 32'h200, 32'hFFFF_FFF0, 1'b1, 32'h1F0);
        send(idx, 3'b010, 32'h1, 32'h1, 32'h300, 32'h8, 1'b1, 32'h308);
        send(idx, 3'b011, 32'h1, 32'h2, 32'h304, 32'h8, 1'b0, 32'h0);
        send(idx, BR_BEQ, 32'h7, 32'h7, 32'hFFFF_FFFC, 32'h8, 1'b1, 32'h4);
        send(idx, BR_BEQ, 32'h7, 32'h7, 32'hFFFF_FFFC, 32'h8, 1'b1, 32'h8);
        send(idx, BR_BEQ, 32'h7, 32'h7, 32'hFFFF_FFFC, 32'h8, 1'b0, 32'h4);
        idle(idx, 4);

        // 8 back-to-back with a 3-cycle consumer stall in the middle.
        for (int k = 0; k < 8; k++) begin
            if (k == 3) stall_cnt[idx] = 3;
            rnd_send(idx);
        end
        idle(idx, 8);

        // Flush with every stage full and a request presented.
        stall_cnt[idx] = 1000;
        idle(idx, 2);
        for (int k = 0; k < idx + 1; k++) rnd_send(idx);
`ifdef BRANCH_STATS_EN
        snap_br = stat_branches[idx];
        snap_mp = stat_mispredicts[idx];
`else
        snap_br = '0;
        snap_mp = '0;
`endif
        in_valid[idx] = 1'b1;
        in_func3[idx] = BR_BNE;
        in_rs1[idx]   = 32'h1;
        in_rs2[idx]   = 32'h2;
        flush[idx]    = 1'b1;
        @(posedge clk);
        #1;
        flush[idx]    = 1'b0;
        in_valid[idx] = 1'b0;
        check($sformatf("s%0d_flush_out_valid", idx + 1), out_valid[idx], 0);
`ifdef BRANCH_STATS_EN
        check($sformatf("s%0d_flush_keeps_branches", idx + 1), stat_branches[idx], snap_br);
        check($sformatf("s%0d_flush_keeps_mispredicts", idx + 1), stat_mispredicts[idx], snap_mp);
`endif
        stall_cnt[idx] = 0;
        idle(idx, 6);

        // Asynchronous reset mid-stream.
        rand_ready[idx] = 1'b1;
        for (int k = 0; k < 4; k++) rnd_send(idx);
        in_valid[idx] = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        check_zero_outputs("midrst", idx);
        @(negedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Random traffic with random consumer back-pressure.
        for (int k = 0; k < 200; k++) begin
            rnd_send(idx);
            if ($urandom_range(0, 7) == 0) idle(idx, $urandom_range(1, 3));
        end
        drain(idx);
    endtask

    initial begin
        exp_t        e;
        logic [2:0]  f6  [6];
        logic        neg [6];
        logic        eqv [6];
        for (int i = 0; i < 2; i++) begin
            flush[i] = 1'b0; in_valid[i] = 1'b0; in_func3[i] = '0; in_rs1[i] = '0;
            in_rs2[i] = '0; in_pc[i] = '0; in_imm[i] = '0; in_pred_taken[i] = 1'b0;
            in_pred_target[i] = '0; out_ready[i] = 1'b1; stall_cnt[i] = 0;
            rand_ready[i] = 1'b0; pending[i] = 0;
        end
        rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) check_zero_outputs("reset", i);

        // Pin the model with hand-derived values.
        f6  = '{BR_BEQ, BR_BNE, BR_BLT, BR_BGE, BR_BLTU, BR_BGEU};
        neg = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        eqv = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int k = 0; k < 6; k++) begin
            e = model(f6[k], 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 1'b0, 32'h0);
            check($sformatf("model_neg_f%0d", f6[k]), e.taken, neg[k]);
            e = model(f6[k], 32'h5, 32'h5, 32'h0, 32'h0, 1'b0, 32'h0);
            check($sformatf("model_eq_f%0d", f6[k]), e.taken, eqv[k]);
        end
        e = model(3'b010, 32'h1, 32'h1, 32'h300, 32'h8, 1'b1, 32'h308);
        check("model_illegal_flag", e.illegal, 1);
        check("model_illegal_mispredict", e.mispredict, 0);
        check("model_illegal_next_pc", e.next_pc, 32'h304);
        e = model(BR_BEQ, 32'h7, 32'h7, 32'hFFFF_FFFC, 32'h8, 1'b1, 32'h4);
        check("model_wrap_next_pc", e.next_pc, 32'h4);
        check("model_wrap_hit", e.mispredict, 0);
        e = model(BR_BEQ, 32'h7, 32'h7, 32'hFFFF_FFFC, 32'h8, 1'b1, 32'h8);
        check("model_wrap_wrong_target", e.mispredict, 1);

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int idx = 0; idx < 2; idx++) run_suite(idx);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, fail_count);
        $finish;
    end

endmodule
